mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM that sequences the shared ALU and the surrounding datapath of the multi-cycle MIPS core. Each instruction is broken into FETCH/DECODE/EXEC/MEM/WB steps. Every step drives the ALU's operand selects (`ALUSrcA`, `ALUSrcB`), `cal_op`, the immediate-extender mode and all architectural write enables. It waits on a memory ready handshake and consumes the ALU's `jump` compare flag to resolve `beq`.

## Interface
- No parameters.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `op` input, 6 bits: IR[31:26]. Stable from DECODE until the next FETCH.
- `funct` input, 6 bits: IR[5:0], same stability as `op`.
- `jump` input, 2 bits: ALU compare flag. Bit 0 = operands equal.
- `mem_ready` input, 1 bit: memory completes the current read or write this cycle.
- `ALUSrcA` output, 2 bits: 01 = PC, 00 = rs. Bit 1 is always 0.
- `ALUSrcB` output, 3 bits: 000 = rt, 001 = extended immediate, 010 = constant 4.
- `cal_op` output, 4 bits: 0000 add, 0001 sub, 0010 or, 0011 equal-compare, 1111 pass B.
- `ext_op` output, 2 bits: 00 zero-extend, 01 sign-extend, 10 sign-extend shifted left 2, 11 imm<<16.
- `pc_wr` output, 1 bit: PC load enable.
- `pc_src` output, 2 bits: 00 ALU result, 01 ALUOut register (branch target), 10 {PC[31:28], IR[25:0], 2'b00}.
- `ir_wr` output, 1 bit: IR load enable.
- `mem_rd` output, 1 bit: memory read request.
- `mem_wr` output, 1 bit: memory write request.
- `reg_wr` output, 1 bit: register-file write enable.
- `reg_dst` output, 1 bit: 1 = rd, 0 = rt.
- `mem_to_reg` output, 1 bit: 1 = write-back data from MDR, 0 = from ALUOut.
- `instr_done` output, 1 bit: one-cycle pulse in the final cycle of each instruction.
- `illegal` output, 1 bit: one-cycle pulse when an unsupported encoding is dropped.
- `state` output, 3 bits: current state, for debug.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 are unreachable and recover to FETCH.
- Outputs are decoded combinationally from `state`, `op`, `funct` and `jump`. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_rd` = 1, `ALUSrcA` = 01, `ALUSrcB` = 010, `cal_op` = 0000.
  - When `mem_ready` = 1: `ir_wr` = 1, `pc_wr` = 1, `pc_src` = 00, next state DECODE. Otherwise stays in FETCH.
- DECODE: drives `ALUSrcA` = 01, `ALUSrcB` = 001, `ext_op` = 10, `cal_op` = 0000 (branch target into ALUOut). Next state depends on the instruction:
  - `j` (op 000010): `pc_wr` = 1, `pc_src` = 10, `instr_done` = 1, next FETCH.
  - nop (op = 0 and funct = 0): `instr_done` = 1, next FETCH.
  - Supported encoding: next EXEC.
  - Anything else: `illegal` = 1, `instr_done` = 1, next FETCH.
- Supported encodings:
  - `addu`: op 0, funct 100001.
  - `subu`: op 0, funct 100011.
  - `ori`: 001101.
  - `lui`: 001111.
  - `lw`: 100011.
  - `sw`: 101011.
  - `beq`: 000100.
- EXEC:
  - `addu`: `cal_op` 0000, B = 000. `subu`: `cal_op` 0001, B = 000. Both next WB.
  - `ori`: `cal_op` 0010, B = 001, `ext_op` 00, next WB.
  - `lui`: `cal_op` 1111, B = 001, `ext_op` 11, next WB.
  - `lw` / `sw`: `cal_op` 0000, B = 001, `ext_op` 01, next MEM.
  - `beq`: `cal_op` 0011, B = 000. `pc_wr` = `jump[0]`, `pc_src` = 01, `instr_done` = 1, next FETCH.
- MEM:
  - `lw`: `mem_rd` = 1. Next WB on `mem_ready`.
  - `sw`: `mem_wr` = 1. On `mem_ready`: `instr_done` = 1, next FETCH.
  - Without `mem_ready` the state holds and the request stays asserted.
- WB: `reg_wr` = 1, then `instr_done` = 1, next FETCH.
  - R-type: `reg_dst` = 1.
  - `lw`: `reg_dst` = 0, `mem_to_reg` = 1.
  - `ori` / `lui`: `reg_dst` = 0.

## Timing
- Reset:
  - In any cycle with `reset` = 1, all enables and pulses (`pc_wr`, `ir_wr`, `mem_rd`, `mem_wr`, `reg_wr`, `instr_done`, `illegal`) are forced to 0.
  - Selects output 0 during reset.
  - `state` is 0 after the edge.
- Reset mid-instruction aborts with no write. The first FETCH follows the reset cycle.
- Latency with `mem_ready` tied to 1: `j` 2 cycles, nop 2, `beq` 3, R-type / `ori` / `lui` 4, `sw` 4, `lw` 5.
- Each cycle of `mem_ready` = 0 in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `jump` is sampled only in the EXEC cycle of `beq`.
- `pc_wr` pulses at most twice per instruction: once in FETCH and once in DECODE or EXEC.

## Test plan
- Reset held 3 cycles during MEM of `sw` with `mem_ready` = 0 → `mem_wr` = 0 on each reset cycle; `state` = 0 after release; next cycle `mem_rd` = 1.
- `addu` (op 0, funct 100001), `mem_ready` = 1 → states 0, 1, 2, 4. EXEC shows `cal_op` = 0000 / `ALUSrcB` = 000. WB shows `reg_wr` = 1, `reg_dst` = 1. `instr_done` in cycle 4.
- `lw` with `mem_ready` low 2 cycles in FETCH and 3 in MEM → total 10 cycles. `mem_rd` held through the waits. WB has `mem_to_reg` = 1.
- `beq` with `jump` = 01, then with `jump` = 00 → EXEC `pc_wr` = 1 / `pc_src` = 01 for the first, `pc_wr` = 0 for the second. Both 3 cycles.
- `lui` then `ori` → EXEC shows `ext_op` = 11 / `cal_op` = 1111, then `ext_op` = 00 / `cal_op` = 0010.
- op 111111 → `illegal` = 1 and `instr_done` = 1 in the DECODE cycle, no `reg_wr` / `mem_wr`, back to FETCH. `j` → `pc_src` = 10 in DECODE, 2 cycles total.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and decodes
// ALU selects, immediate-extender mode and write enables from the current state.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [1:0] jump,
    input  logic       mem_ready,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [3:0] cal_op,
    output logic [1:0] ext_op,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       ir_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    logic [2:0] state_q, state_d;
    logic       is_rtype_alu;
    logic       is_supported;

    assign is_rtype_alu = (op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
    assign is_supported = is_rtype_alu || (op == OP_ORI) || (op == OP_LUI) ||
                          (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    assign state        = state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
        state_d    = state_q;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 3'b000;
        cal_op     = 4'b0000;
        ext_op     = 2'b00;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd  = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 3'b010;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut while the opcode is decoded.
                ALUSrcA = 2'b01;
                ALUSrcB = 3'b001;
                ext_op  = 2'b10;
                if (op == OP_J) begin
                    pc_wr      = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (op == OP_RTYPE && funct == 6'd0) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_supported) begin
                    state_d = S_EXEC;
                end else begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        cal_op  = (funct == FN_SUBU) ? 4'b0001 : 4'b0000;
                        state_d = S_WB;
                    end
                    OP_ORI: begin
                        cal_op  = 4'b0010;
                        ALUSrcB = 3'b001;
                        state_d = S_WB;
                    end
                    OP_LUI: begin
                        cal_op  = 4'b1111;
                        ALUSrcB = 3'b001;
                        ext_op  = 2'b11;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrcB = 3'b001;
                        ext_op  = 2'b01;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        cal_op     = 4'b0011;
                        pc_wr      = jump[0];
                        pc_src     = 2'b01;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    mem_rd = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (op == OP_SW) begin
                    mem_wr = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (op == OP_RTYPE);
                mem_to_reg = (op == OP_LW);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset aborts the instruction: no enables, pulses or selects leave the block.
        if (reset) begin
            ALUSrcA    = 2'b00;
            ALUSrcB    = 3'b000;
            cal_op     = 4'b0000;
            ext_op     = 2'b00;
            pc_wr      = 1'b0;
            pc_src     = 2'b00;
            ir_wr      = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            reg_wr     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class cycle by cycle
// and compares logged control outputs against hand-derived values.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic [1:0] jump;
    logic       mem_ready;
    logic [1:0] ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [3:0] cal_op;
    logic [1:0] ext_op;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, instr_done, illegal;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] a;
        logic [2:0] b;
        logic [3:0] cal;
        logic [1:0] ext;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, mrd, mwr, rw, rdst, m2r, done, ill;
    } snap_t;

    snap_t log_q [20];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .jump(jump),
        .mem_ready(mem_ready), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .cal_op(cal_op), .ext_op(ext_op), .pc_wr(pc_wr), .pc_src(pc_src),
        .ir_wr(ir_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from FETCH; bit i of mask is mem_ready in cycle i.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic [1:0] jp, input logic [31:0] mask, output int cycles);
        op = o; funct = f; jump = jp; cycles = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = mask[i];
            @(negedge clk);
            log_q[i] = '{st: state, a: ALUSrcA, b: ALUSrcB, cal: cal_op, ext: ext_op,
                         pcw: pc_wr, pcs: pc_src, irw: ir_wr, mrd: mem_rd, mwr: mem_wr,
                         rw: reg_wr, rdst: reg_dst, m2r: mem_to_reg, done: instr_done,
                         ill: illegal};
            @(posedge clk); #1;
            cycles = i + 1;
            if (log_q[i].done) break;
        end
        check({tag, "_terminated"}, log_q[cycles-1].done, 1'b1);
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; jump = '0; mem_ready = 1'b1;

        // Power-on reset: outputs forced quiet, state cleared after the edge.
        @(negedge clk);
        check("rst_pc_wr", pc_wr, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_srcB", ALUSrcB, 3'b000);
        check("rst_ir_wr", ir_wr, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // addu
        run_instr("addu", 6'd0, 6'b100001, 2'b00, 32'hFFFF_FFFF, cyc);
        check("addu_cycles", cyc, 4);
        check("addu_fetch", {log_q[0].st, log_q[0].a, log_q[0].b, log_q[0].mrd, log_q[0].irw, log_q[0].pcw},
              {3'd0, 2'b01, 3'b010, 3'b111});
        check("addu_states", {log_q[1].st, log_q[2].st, log_q[3].st}, {3'd1, 3'd2, 3'd4});
        check("addu_decode", {log_q[1].b, log_q[1].ext}, {3'b001, 2'b10});
        check("addu_exec", {log_q[2].cal, log_q[2].b}, {4'b0000, 3'b000});
        check("addu_wb", {log_q[3].rw, log_q[3].rdst, log_q[3].m2r, log_q[3].done}, 4'b1101);

        // subu, with mem_ready low in DECODE/EXEC (must be ignored)
        run_instr("subu", 6'd0, 6'b100011, 2'b00, 32'hFFFF_FFF9, cyc);
        check("subu_cycles", cyc, 4);
        check("subu_exec", log_q[2].cal, 4'b0001);

        // lw: 2 FETCH waits, 3 MEM waits
        run_instr("lw", 6'b100011, 6'd0, 2'b00, 32'hFFFF_FF1C, cyc);
        check("lw_cycles", cyc, 10);
        check("lw_fetch_wait", {log_q[0].mrd, log_q[0].irw, log_q[1].mrd, log_q[1].irw, log_q[1].st}, {4'b1010, 3'd0});
        check("lw_fetch_go", {log_q[2].irw, log_q[2].pcw}, 2'b11);
        check("lw_exec", {log_q[4].st, log_q[4].ext, log_q[4].b, log_q[4].cal}, {3'd2, 2'b01, 3'b001, 4'b0000});
        for (int i = 5; i <= 8; i++)
            check($sformatf("lw_mem%0d", i), {log_q[i].st, log_q[i].mrd, log_q[i].mwr}, {3'd3, 2'b10});
        check("lw_wb", {log_q[9].st, log_q[9].rw, log_q[9].rdst, log_q[9].m2r}, {3'd4, 3'b101});

        // beq taken / not taken
        run_instr("beq_t", 6'b000100, 6'd0, 2'b01, 32'hFFFF_FFFF, cyc);
        check("beq_t_cycles", cyc, 3);
        check("beq_t_exec", {log_q[2].cal, log_q[2].pcw, log_q[2].pcs}, {4'b0011, 1'b1, 2'b01});
        run_instr("beq_n", 6'b000100, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("beq_n_cycles", cyc, 3);
        check("beq_n_exec", log_q[2].pcw, 1'b0);

        // lui then ori
        run_instr("lui", 6'b001111, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("lui_cycles", cyc, 4);
        check("lui_exec", {log_q[2].ext, log_q[2].cal, log_q[2].b}, {2'b11, 4'b1111, 3'b001});
        check("lui_wb", {log_q[3].rw, log_q[3].rdst}, 2'b10);
        run_instr("ori", 6'b001101, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("ori_exec", {log_q[2].ext, log_q[2].cal, log_q[2].b}, {2'b00, 4'b0010, 3'b001});

        // illegal op
        run_instr("ill", 6'b111111, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("ill_cycles", cyc, 2);
        check("ill_decode", {log_q[1].ill, log_q[1].done, log_q[1].rw, log_q[1].mwr}, 4'b1100);

        // j
        run_instr("j", 6'b000010, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("j_start_state", log_q[0].st, 3'd0);
        check("j_cycles", cyc, 2);
        check("j_decode", {log_q[1].pcw, log_q[1].pcs, log_q[1].ill}, {1'b1, 2'b10, 1'b0});

        // nop
        run_instr("nop", 6'd0, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("nop_cycles", cyc, 2);
        check("nop_decode", {log_q[1].ill, log_q[1].pcw}, 2'b00);

        // sw
        run_instr("sw", 6'b101011, 6'd0, 2'b00, 32'hFFFF_FFFF, cyc);
        check("sw_cycles", cyc, 4);
        check("sw_mem", {log_q[3].st, log_q[3].mwr, log_q[3].mrd, log_q[3].rw}, {3'd3, 3'b100});

        // Reset held 3 cycles during a stalled sw MEM
        op = 6'b101011; funct = '0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_stall_mem", {state, mem_wr}, {3'd3, 1'b1});
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_mid_mem_wr%0d", i), {mem_wr, instr_done, reg_wr}, 3'b000);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_release", {state, mem_rd, mem_wr}, {3'd0, 2'b10});
        @(posedge clk); #1;

        // Recover with one more addu after the abort
        run_instr("addu2", 6'd0, 6'b100001, 2'b00, 32'hFFFF_FFFF, cyc);
        check("addu2_cycles", cyc, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
